rca_seq_ctrl: RTL and testbench

//   Multi-cycle controller that sequences the 3-bit ripple-carry adder slice to add or subtract WIDTH-bit operands.
//   - Accepts one operation per valid/ready handshake.
//   - Feeds the adder one 3-bit slice per cycle, LSB slice first, and holds the inter-slice carry in a register.
//   - Assembles the result and presents it on a valid/ready output.
//   - Sits between the Tiny Tapeout user I/O wrapper and one externally instantiated 3-bit adder slice.
//

---
 rtl/rca_seq_ctrl.sv | 106 ++++++++++
 tb/tb_rca_seq_ctrl.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rca_seq_ctrl.sv
// Sequencer that drives one external 3-bit ripple-carry slice, LSB slice first,
// to add or subtract WIDTH-bit operands behind valid/ready handshakes.
module rca_seq_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [2:0]       rca_a,
  output logic [2:0]       rca_b,
  output logic             rca_cin,
  input  logic [2:0]       rca_sum,
  input  logic             rca_cout
);
  localparam int N     = WIDTH / 3;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % 3) != 0 || WIDTH < 3) begin : g_width_chk
    $error("rca_seq_ctrl: WIDTH must be a multiple of 3 and >= 3");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [N-1:0][2:0]      a_q, a_d, b_q, b_d, res_q, res_d;
  logic                   last_slice;

  assign last_slice = (idx_q == IDX_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_res   = '0;
    out_cout  = 1'b0;
    out_ovf   = 1'b0;
    rca_a     = 3'd0;
    rca_b     = 3'd0;
    rca_cin   = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtract is A + ~B + 1: the +1 rides in as the first slice carry.
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        rca_a          = a_q[idx_q];
        rca_b          = b_q[idx_q];
        rca_cin        = carry_q;
        res_d[idx_q]   = rca_sum;
        carry_d        = rca_cout;
        if (last_slice) state_d = DONE;
        else            idx_d   = idx_q + 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        out_res   = res_q;
        out_cout  = carry_q;
        // b_q is already inverted for subtract, so one rule covers both ops.
        out_ovf   = (a_q[N-1][2] == b_q[N-1][2]) && (res_q[N-1][2] != a_q[N-1][2]);
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl with a behavioural 3-bit adder slice.
module tb_rca_seq_ctrl;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, in_sub;
  logic [W-1:0] in_a, in_b;
  logic         out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0] out_res;
  logic [2:0]   rca_a, rca_b, rca_sum;
  logic         rca_cin, rca_cout;

  int n_cmp = 0;
  int n_err = 0;
  int lat;
  logic [2:0] sl_a [4];
  logic [2:0] sl_b [4];
  logic       sl_c [4];

  always #5 clk = ~clk;

  assign {rca_cout, rca_sum} = {1'b0, rca_a} + {1'b0, rca_b} + {3'b000, rca_cin};

  rca_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_cout(out_cout), .out_ovf(out_ovf),
    .rca_a(rca_a), .rca_b(rca_b), .rca_cin(rca_cin),
    .rca_sum(rca_sum), .rca_cout(rca_cout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Handshake one op and run it to DONE; leaves out_ready low so the caller
  // decides when to accept. Records the slice drive of each RUN cycle.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    int guard = 0;
    while (!in_ready && guard < 20) begin tick(); guard++; end
    chk("in_ready_before_op", {31'd0, in_ready}, 32'd1);
    in_a = a; in_b = b; in_sub = sub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = '1; in_b = '1; in_sub = ~sub;  // must be ignored after the handshake
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < 4) begin sl_a[lat] = rca_a; sl_b[lat] = rca_b; sl_c[lat] = rca_cin; end
      tick(); lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_accept", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic sub, input logic [W-1:0] er, input logic ec, input logic eo);
    start_op(a, b, sub);
    // four RUN cycles after the handshake edge, result visible from the fifth
    chk({tag, "_lat"}, lat, 32'd4);
    chk({tag, "_res"}, {20'd0, out_res}, {20'd0, er});
    chk({tag, "_cout"}, {31'd0, out_cout}, {31'd0, ec});
    chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    accept();
  endtask

  initial begin
    logic [W-1:0] held;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_res", {20'd0, out_res}, 32'd0);
    chk("rst_rca", {25'd0, rca_a, rca_b, rca_cin}, 32'd0);
    tick(); rst_n = 1'b1; tick();

    op("add_0ff_001", 12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0, 1'b0);
    op("add_fff_001", 12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    op("add_7ff_001", 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
    op("sub_005_007", 12'h005, 12'h007, 1'b1, 12'hFFE, 1'b0, 1'b0);
    op("sub_800_001", 12'h800, 12'h001, 1'b1, 12'h7FF, 1'b1, 1'b1);

    // slice sequence for ABC + 123 = BDF: a slices 4,7,2,5; b slices 3,4,4,0;
    // carries into each slice 0,0,1,0
    start_op(12'hABC, 12'h123, 1'b0);
    chk("slice_lat", lat, 32'd4);
    chk("slice_a", {20'd0, sl_a[3], sl_a[2], sl_a[1], sl_a[0]}, {20'd0, 3'd5, 3'd2, 3'd7, 3'd4});
    chk("slice_b", {20'd0, sl_b[3], sl_b[2], sl_b[1], sl_b[0]}, {20'd0, 3'd0, 3'd4, 3'd4, 3'd3});
    chk("slice_cin", {28'd0, sl_c[3], sl_c[2], sl_c[1], sl_c[0]}, {28'd0, 4'b0100});
    chk("slice_res", {20'd0, out_res}, 32'h0BDF);
    chk("slice_rca_idle_in_done", {25'd0, rca_a, rca_b, rca_cin}, 32'd0);

    // backpressure: ten cycles in DONE with a competing request
    in_a = 12'h111; in_b = 12'h222; in_sub = 1'b0; in_valid = 1'b1;
    held = out_res;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_res", {20'd0, out_res}, 32'h0BDF);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    chk("bp_cout", {31'd0, out_cout}, 32'd0);
    chk("bp_ovf", {31'd0, out_ovf}, 32'd0);
    chk("bp_held", {20'd0, out_res}, {20'd0, held});
    in_valid = 1'b0;
    accept();

    // reset in the 2nd RUN cycle aborts the op
    in_a = 12'h555; in_b = 12'h0AA; in_sub = 1'b0; in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    tick();
    chk("mid_run_rca_live", {29'd0, rca_a}, 32'd2);
    rst_n = 1'b0; #1;
    chk("rstmid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstmid_rca", {25'd0, rca_a, rca_b, rca_cin}, 32'd0);
    tick(); rst_n = 1'b1; tick();
    op("post_rst_010_020", 12'h010, 12'h020, 1'b0, 12'h030, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
